k_and_s_seq_control: RTL and testbench

- Parametrised multi-cycle control unit for the K&S processor; next generation of the basic fetch/decode/execute sequencer.
- Adds configurable memory wait states, a full conditional-branch set, sticky halt, illegal-opcode reporting and a retired-instruction counter.
- Sits between the instruction decoder (decoded_instruction_type from k_and_s_pkg) and the datapath/RAM enables.

---
 rtl/k_and_s_seq_control.sv | 203 ++++++++++++++++++++
 tb/tb_k_and_s_seq_control.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/k_and_s_seq_control.sv
// K&S multi-cycle sequencer: fetch/decode/execute with RAM wait states, sticky halt, illegal-opcode pulse, retire counter; CTRL_STEP_EN adds single-step parking.
// Latency fetch-to-fetch: ALU/branch MEM_WAIT+3, LOAD/STORE 2*MEM_WAIT+3, NOP/illegal MEM_WAIT+2 cycles.
// No backpressure: RAM is assumed ready after MEM_WAIT cycles; only STEP_HOLD (released by step) stalls the sequence.
package k_and_s_pkg;
  typedef enum logic [4:0] {
    I_NOP    = 5'd0,
    I_LOAD   = 5'd1,
    I_STORE  = 5'd2,
    I_MOVE   = 5'd3,
    I_ADD    = 5'd4,
    I_SUB    = 5'd5,
    I_AND    = 5'd6,
    I_OR     = 5'd7,
    I_BRANCH = 5'd8,
    I_BZERO  = 5'd9,
    I_BNZERO = 5'd10,
    I_BNEG   = 5'd11,
    I_BNNEG  = 5'd12,
    I_BOV    = 5'd13,
    I_BNOV   = 5'd14,
    I_HALT   = 5'd15
  } decoded_instruction_type;
endpackage

module k_and_s_seq_control
  import k_and_s_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  input  logic                    step,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    write_reg_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic [1:0]              operation,
  output logic                    halt,
  output logic                    illegal_instr,
  output logic                    instr_done,
  output logic [CNT_W-1:0]        instr_count
);

  localparam int WW = (MEM_WAIT < 1) ? 1 : $clog2(MEM_WAIT + 1);
  localparam logic [WW-1:0] LAST = WW'(MEM_WAIT);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC, LOAD, STORE, BRANCH, HALTED, STEP_HOLD
  } state_t;

`ifdef CTRL_STEP_EN
  localparam state_t S_RET = STEP_HOLD;
  logic unused_inputs;
  assign unused_inputs = unsigned_overflow;
`else
  localparam state_t S_RET = FETCH;
  logic unused_inputs;
  assign unused_inputs = unsigned_overflow ^ step;
`endif

  state_t          st_q, st_d;
  logic [WW-1:0]   cnt_q, cnt_d;
  logic            retire_d, illegal_d;
  logic            last;
  logic            pc_en_q;
  logic            is_alu;
  logic            taken;
  logic [1:0]      alu_op;

  assign last = (cnt_q == LAST);

  always_comb begin
    st_d      = st_q;
    cnt_d     = '0;
    retire_d  = 1'b0;
    illegal_d = 1'b0;
    case (st_q)
      IDLE: st_d = FETCH;
      FETCH: begin
        if (last) st_d = DECODE;
        else      cnt_d = cnt_q + 1'b1;
      end
      DECODE: begin
        case (decoded_instruction)
          I_ADD, I_SUB, I_AND, I_OR, I_MOVE: st_d = EXEC;
          I_LOAD:  st_d = LOAD;
          I_STORE: st_d = STORE;
          I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV: st_d = BRANCH;
          I_HALT: begin
            st_d     = HALTED;
            retire_d = 1'b1;
          end
          I_NOP: begin
            st_d     = S_RET;
            retire_d = 1'b1;
          end
          default: begin
            st_d      = S_RET;
            retire_d  = 1'b1;
            illegal_d = 1'b1;
          end
        endcase
      end
      EXEC, BRANCH: begin
        st_d     = S_RET;
        retire_d = 1'b1;
      end
      LOAD, STORE: begin
        if (last) begin
          st_d     = S_RET;
          retire_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HALTED: st_d = HALTED;
`ifdef CTRL_STEP_EN
      STEP_HOLD: if (step) st_d = FETCH;
`endif
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    alu_op = 2'b00;
    is_alu = 1'b0;
    case (decoded_instruction)
      I_ADD:  begin alu_op = 2'b00; is_alu = 1'b1; end
      I_SUB:  begin alu_op = 2'b01; is_alu = 1'b1; end
      I_AND:  begin alu_op = 2'b10; is_alu = 1'b1; end
      I_OR:   begin alu_op = 2'b11; is_alu = 1'b1; end
      I_MOVE: alu_op = 2'b11;
      default: ;
    endcase
  end

  // Flags are only looked at while BRANCH is the current state.
  always_comb begin
    taken = 1'b0;
    case (decoded_instruction)
      I_BRANCH: taken = 1'b1;
      I_BZERO:  taken = zero_op;
      I_BNZERO: taken = !zero_op;
      I_BNEG:   taken = neg_op;
      I_BNNEG:  taken = !neg_op;
      I_BOV:    taken = signed_overflow;
      I_BNOV:   taken = !signed_overflow;
      default:  taken = 1'b0;
    endcase
  end

  assign branch    = (st_q == BRANCH) && taken;
  assign pc_enable = pc_en_q | branch;

  // Outputs are registered from the next-state decode so they align with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q             <= IDLE;
      cnt_q            <= '0;
      pc_en_q          <= 1'b0;
      ir_enable        <= 1'b0;
      write_reg_enable <= 1'b0;
      addr_sel         <= 1'b0;
      c_sel            <= 1'b0;
      flags_reg_enable <= 1'b0;
      ram_write_enable <= 1'b0;
      operation        <= 2'b00;
      halt             <= 1'b0;
      illegal_instr    <= 1'b0;
      instr_done       <= 1'b0;
      instr_count      <= '0;
    end else begin
      st_q             <= st_d;
      cnt_q            <= cnt_d;
      pc_en_q          <= (st_d == DECODE);
      ir_enable        <= (st_d == FETCH) && (cnt_d == LAST);
      addr_sel         <= (st_d == LOAD) || (st_d == STORE);
      write_reg_enable <= (st_d == EXEC) || ((st_d == LOAD) && (cnt_d == LAST));
      c_sel            <= (st_d == LOAD) && (cnt_d == LAST);
      ram_write_enable <= (st_d == STORE) && (cnt_d == LAST);
      flags_reg_enable <= (st_d == EXEC) && is_alu;
      operation        <= (st_d == EXEC) ? alu_op : 2'b00;
      halt             <= (st_d == HALTED);
      illegal_instr    <= illegal_d;
      instr_done       <= retire_d;
      if (retire_d) instr_count <= instr_count + 1'b1;
    end
  end

  a_no_dual_write: assert property (@(posedge clk) disable iff (rst)
    !(ram_write_enable && write_reg_enable));

endmodule

// File: tb/tb_k_and_s_seq_control.sv
// Directed bench for k_and_s_seq_control: per-cycle expected control vectors queued from an instruction timing model.
module tb_k_and_s_seq_control;
  import k_and_s_pkg::*;

  localparam int MW = 2;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  decoded_instruction_type decoded_instruction = I_NOP;
  logic zero_op = 1'b0, neg_op = 1'b0, unsigned_overflow = 1'b0, signed_overflow = 1'b0, step = 1'b0;
  logic branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel, flags_reg_enable, ram_write_enable;
  logic [1:0] operation;
  logic halt, illegal_instr, instr_done;
  logic [CW-1:0] instr_count;

  k_and_s_seq_control #(.MEM_WAIT(MW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .decoded_instruction(decoded_instruction),
    .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(unsigned_overflow),
    .signed_overflow(signed_overflow), .step(step),
    .branch(branch), .pc_enable(pc_enable), .ir_enable(ir_enable),
    .write_reg_enable(write_reg_enable), .addr_sel(addr_sel), .c_sel(c_sel),
    .flags_reg_enable(flags_reg_enable), .ram_write_enable(ram_write_enable),
    .operation(operation), .halt(halt), .illegal_instr(illegal_instr),
    .instr_done(instr_done), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel, flags_reg_enable, ram_write_enable;
    logic [1:0] operation;
    logic halt, illegal_instr, instr_done;
    logic [CW-1:0] instr_count;
  } ctl_t;

  typedef struct packed {
    logic rst;
    decoded_instruction_type ins;
    logic z, n, uo, so, stp;
    ctl_t exp;
  } ent_t;

  ent_t  sb[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  decoded_instruction_type ir_m = I_NOP;
  decoded_instruction_type bad_op;
  logic [CW-1:0] cnt_m = '0;
  logic pend_done = 1'b0, pend_ill = 1'b0;

  function automatic ctl_t blank();
    ctl_t c;
    c = '0;
    c.instr_count = cnt_m;
    return c;
  endfunction

  task automatic push(input string tag, input logic r, input ctl_t e, input logic z, input logic n, input logic v);
    ent_t x;
    x.rst = r; x.ins = ir_m; x.z = z; x.n = n; x.so = v;
    x.uo = 1'($urandom); x.stp = 1'($urandom); x.exp = e;
    sb.push_back(x);
    tag_q.push_back(tag);
  endtask

  task automatic push_rnd(input string tag, input ctl_t e);
    push(tag, 1'b0, e, 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic drain();
    ent_t  x;
    ctl_t  obs;
    string t;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      t = tag_q.pop_front();
      @(posedge clk); #1;
      rst = x.rst; decoded_instruction = x.ins;
      zero_op = x.z; neg_op = x.n; unsigned_overflow = x.uo; signed_overflow = x.so; step = x.stp;
      @(negedge clk);
      obs = {branch, pc_enable, ir_enable, write_reg_enable, addr_sel, c_sel, flags_reg_enable,
             ram_write_enable, operation, halt, illegal_instr, instr_done, instr_count};
      checks++;
      assert (obs === x.exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", t, obs, x.exp);
      end
    end
  endtask

  task automatic reset_seq(input string tag, input int n);
    cnt_m = '0; pend_done = 1'b0; pend_ill = 1'b0;
    for (int i = 0; i < n; i++) push($sformatf("%s.rst%0d", tag, i), 1'b1, blank(), 1'b0, 1'b0, 1'b0);
    push($sformatf("%s.idle", tag), 1'b0, blank(), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic fetch_decode(input string tag, input decoded_instruction_type op);
    ctl_t e;
    for (int i = 0; i <= MW; i++) begin
      e = blank();
      if (i == 0) begin
        e.instr_done = pend_done;
        e.illegal_instr = pend_ill;
      end
      e.ir_enable = (i == MW);
      push_rnd($sformatf("%s.fetch%0d", tag, i), e);
    end
    pend_done = 1'b0; pend_ill = 1'b0;
    ir_m = op;
    e = blank();
    e.pc_enable = 1'b1;
    push_rnd($sformatf("%s.decode", tag), e);
  endtask

  task automatic run_instr(input string tag, input decoded_instruction_type op,
                           input logic z, input logic n, input logic v);
    ctl_t e;
    logic tk;
    fetch_decode(tag, op);
    case (op)
      I_ADD, I_SUB, I_AND, I_OR, I_MOVE: begin
        e = blank();
        e.write_reg_enable = 1'b1;
        e.flags_reg_enable = (op != I_MOVE);
        case (op)
          I_SUB:        e.operation = 2'b01;
          I_AND:        e.operation = 2'b10;
          I_OR, I_MOVE: e.operation = 2'b11;
          default:      e.operation = 2'b00;
        endcase
        push_rnd({tag, ".exec"}, e);
      end
      I_LOAD, I_STORE: begin
        for (int i = 0; i <= MW; i++) begin
          e = blank();
          e.addr_sel = 1'b1;
          if (i == MW) begin
            if (op == I_LOAD) begin
              e.write_reg_enable = 1'b1;
              e.c_sel = 1'b1;
            end else begin
              e.ram_write_enable = 1'b1;
            end
          end
          push_rnd($sformatf("%s.mem%0d", tag, i), e);
        end
      end
      I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV: begin
        case (op)
          I_BZERO:  tk = z;
          I_BNZERO: tk = !z;
          I_BNEG:   tk = n;
          I_BNNEG:  tk = !n;
          I_BOV:    tk = v;
          I_BNOV:   tk = !v;
          default:  tk = 1'b1;
        endcase
        e = blank();
        e.branch = tk;
        e.pc_enable = tk;
        push({tag, ".br"}, 1'b0, e, z, n, v);
      end
      I_HALT: begin
        cnt_m++;
        for (int i = 0; i < 20; i++) begin
          e = blank();
          e.halt = 1'b1;
          e.instr_done = (i == 0);
          push_rnd($sformatf("%s.halted%0d", tag, i), e);
        end
      end
      I_NOP: ;
      default: pend_ill = 1'b1;
    endcase
    if (op != I_HALT) begin
      pend_done = 1'b1;
      cnt_m++;
    end
    drain();
  endtask

  task automatic store_reset(input string tag);
    fetch_decode(tag, I_STORE);
    cnt_m = '0; pend_done = 1'b0; pend_ill = 1'b0;
    for (int i = 0; i < 3; i++) push($sformatf("%s.rst%0d", tag, i), 1'b1, blank(), 1'b0, 1'b0, 1'b0);
    push({tag, ".idle"}, 1'b0, blank(), 1'b0, 1'b0, 1'b0);
    drain();
  endtask

  initial begin
    bad_op = decoded_instruction_type'(5'd21);
    reset_seq("reset", 3);
    drain();
    run_instr("add",    I_ADD,    1'b0, 1'b0, 1'b0);
    run_instr("sub",    I_SUB,    1'b0, 1'b0, 1'b0);
    run_instr("and",    I_AND,    1'b0, 1'b0, 1'b0);
    run_instr("or",     I_OR,     1'b0, 1'b0, 1'b0);
    run_instr("move",   I_MOVE,   1'b0, 1'b0, 1'b0);
    run_instr("load",   I_LOAD,   1'b0, 1'b0, 1'b0);
    run_instr("store",  I_STORE,  1'b0, 1'b0, 1'b0);
    run_instr("bz0",    I_BZERO,  1'b0, 1'b1, 1'b1);
    run_instr("bz1",    I_BZERO,  1'b1, 1'b0, 1'b0);
    run_instr("bnz1",   I_BNZERO, 1'b1, 1'b0, 1'b0);
    run_instr("bneg1",  I_BNEG,   1'b0, 1'b1, 1'b0);
    run_instr("bnneg0", I_BNNEG,  1'b1, 1'b0, 1'b1);
    run_instr("bnneg1", I_BNNEG,  1'b0, 1'b1, 1'b0);
    run_instr("bov0",   I_BOV,    1'b1, 1'b1, 1'b0);
    run_instr("bov1",   I_BOV,    1'b0, 1'b0, 1'b1);
    run_instr("bnov0",  I_BNOV,   1'b0, 1'b0, 1'b0);
    run_instr("br",     I_BRANCH, 1'b0, 1'b0, 1'b0);
    run_instr("nop",    I_NOP,    1'b0, 1'b0, 1'b0);
    if (cnt_m == '0) run_instr("nop_pad", I_NOP, 1'b0, 1'b0, 1'b0);
    store_reset("store_rst");
    for (int i = 0; i < 5; i++) run_instr($sformatf("nopw%0d", i), I_NOP, 1'b0, 1'b0, 1'b0);
    run_instr("illegal", bad_op, 1'b0, 1'b0, 1'b0);
    run_instr("add2",    I_ADD,  1'b0, 1'b0, 1'b0);
    run_instr("halt",    I_HALT, 1'b0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
